// File: rtl/c880_alu_reg_if.sv
// Packed operand/control vector and registered result vector of the c880-style ALU block.
interface c880_alu_reg_if #(
  parameter int IN_W  = 60,
  parameter int OUT_W = 26
);
  logic [IN_W-1:0]  in;
  logic [OUT_W-1:0] out;

  modport master (output in, input out);
  modport slave  (input in, output out);
endinterface

// File: rtl/c880_alu_reg.sv
// 8-bit ALU, byte merge, equality compare and priority encoder feeding one
// capture-enabled output register (c880-style 60-in / 26-out packing).
module c880_alu_reg #(
  parameter int IN_W  = 60,
  parameter int OUT_W = 26
) (
  input logic            clk,
  input logic            rst_n,
  c880_alu_reg_if.slave  bus
);

  function automatic logic [2:0] prio_enc(input logic [7:0] v);
    prio_enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) prio_enc = 3'(i);
    end
  endfunction

  function automatic logic [8:0] alu_sum(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
    case (op)
      3'b000:  alu_sum = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      3'b001:  alu_sum = {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
      3'b010:  alu_sum = {1'b0, a & b};
      3'b011:  alu_sum = {1'b0, a | b};
      3'b100:  alu_sum = {1'b0, a ^ b};
      3'b101:  alu_sum = {1'b0, ~a};
      3'b110:  alu_sum = {a[7], a[6:0], cin};
      default: alu_sum = {a[0], cin, a[7:1]};
    endcase
  endfunction

  // Stage p0: field extraction and combinational core
  logic [7:0]       a_p0, b_p0, c_p0, d_p0, mask_p0, e_p0;
  logic [2:0]       op_p0;
  logic             cin_p0, cap_p0;
  logic [8:0]       sum_p0;
  logic [7:0]       r_p0, m_p0;
  logic             v_p0;
  logic [OUT_W-1:0] next_p0;
  logic [6:0]       unused_rsv_p0;

  assign a_p0          = bus.in[7:0];
  assign b_p0          = bus.in[15:8];
  assign c_p0          = bus.in[23:16];
  assign d_p0          = bus.in[31:24];
  assign op_p0         = bus.in[34:32];
  assign cin_p0        = bus.in[35];
  assign mask_p0       = bus.in[43:36];
  assign e_p0          = bus.in[51:44];
  assign cap_p0        = bus.in[52];
  assign unused_rsv_p0 = bus.in[IN_W-1:53];

  assign sum_p0 = alu_sum(op_p0, a_p0, b_p0, cin_p0);
  assign r_p0   = sum_p0[7:0];
  assign m_p0   = (c_p0 & mask_p0) | (d_p0 & ~mask_p0);

  // Overflow only exists for the two arithmetic ops; subtract sees ~B as the second operand.
  always_comb begin
    v_p0 = 1'b0;
    case (op_p0)
      3'b000:  v_p0 = (a_p0[7] == b_p0[7]) && (r_p0[7] != a_p0[7]);
      3'b001:  v_p0 = (a_p0[7] != b_p0[7]) && (r_p0[7] != a_p0[7]);
      default: v_p0 = 1'b0;
    endcase
  end

  assign next_p0 = {(e_p0 != 8'd0),
                    prio_enc(e_p0),
                    (a_p0 == b_p0),
                    v_p0,
                    m_p0,
                    r_p0[7],
                    ^r_p0,
                    (r_p0 == 8'd0),
                    sum_p0[8],
                    r_p0};

  // Stage p1: capture-enabled output register
  logic [OUT_W-1:0] out_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1 <= '0;
    end else if (cap_p0) begin
      out_p1 <= next_p0;
    end
  end

  assign bus.out = out_p1;

endmodule

// File: tb/tb_c880_alu_reg.sv
// Randomised and directed bench for c880_alu_reg against an arithmetic reference model.
module tb_c880_alu_reg;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  c880_alu_reg_if bus ();

  c880_alu_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [59:0] mk(input int a, input int b, input int c, input int d,
                                     input int op, input int cin, input int mask,
                                     input int e, input int cap, input int rsv);
    logic [59:0] v;
    v = '0;
    v[7:0]   = a[7:0];
    v[15:8]  = b[7:0];
    v[23:16] = c[7:0];
    v[31:24] = d[7:0];
    v[34:32] = op[2:0];
    v[35]    = cin[0];
    v[43:36] = mask[7:0];
    v[51:44] = e[7:0];
    v[52]    = cap[0];
    v[59:53] = rsv[6:0];
    return v;
  endfunction

  function automatic logic [25:0] pack(input int r, input int co, input int z, input int p,
                                       input int n, input int m, input int v, input int eq,
                                       input int pi, input int pv);
    logic [25:0] o;
    o = '0;
    o[7:0]   = r[7:0];
    o[8]     = co[0];
    o[9]     = z[0];
    o[10]    = p[0];
    o[11]    = n[0];
    o[19:12] = m[7:0];
    o[20]    = v[0];
    o[21]    = eq[0];
    o[24:22] = pi[2:0];
    o[25]    = pv[0];
    return o;
  endfunction

  // Reference: integer arithmetic; overflow judged by the signed result leaving [-128,127].
  function automatic logic [25:0] model(input logic [59:0] vec);
    int a, b, c, d, op, cin, mask, e, sa, sb, r9, sr, vf, r, pi;
    a = int'(vec[7:0]);   b = int'(vec[15:8]);  c = int'(vec[23:16]); d = int'(vec[31:24]);
    op = int'(vec[34:32]); cin = int'(vec[35]); mask = int'(vec[43:36]); e = int'(vec[51:44]);
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    vf = 0;
    case (op)
      0: begin r9 = a + b + cin;         sr = sa + sb + cin;      vf = (sr > 127 || sr < -128); end
      1: begin r9 = a + (255 - b) + cin; sr = sa - sb - 1 + cin;  vf = (sr > 127 || sr < -128); end
      2: r9 = a & b;
      3: r9 = a | b;
      4: r9 = a ^ b;
      5: r9 = 255 - a;
      6: r9 = a * 2 + cin;
      default: r9 = (a % 2) * 256 + cin * 128 + a / 2;
    endcase
    r = r9 % 256;
    pi = 0;
    for (int k = 0; k < 8; k++) if (e >= (1 << k)) pi = k;
    return pack(r, r9 / 256, (r == 0), ($countones(r[7:0]) % 2), (r / 128),
                (c & mask) | (d & (255 - mask)), vf, (a == b), pi, (e != 0));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    bus.in = '1;
    step();
    step();
    checks++;
    if (bus.out !== 26'h0) begin
      errors++;
      $display("FAIL reset_hold out=%h want=%h", bus.out, 26'h0);
    end
    rst_n  = 1'b1;
    bus.in = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    checks++;
    if (bus.out !== 26'h0200200) begin
      errors++;
      $display("FAIL reset_first_capture out=%h want=%h", bus.out, 26'h0200200);
    end
  endtask

  task automatic test_add_sub();
    logic [25:0] exp;
    bus.in = mk(8'hFF, 8'h01, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    exp = pack(8'h00, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.out !== exp) begin
      errors++;
      $display("FAIL add_wrap out=%h want=%h", bus.out, exp);
    end
    bus.in = mk(8'h80, 8'h01, 0, 0, 1, 1, 0, 0, 1, 0);
    step();
    exp = pack(8'h7F, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    checks++;
    if (bus.out !== exp) begin
      errors++;
      $display("FAIL sub_overflow out=%h want=%h", bus.out, exp);
    end
  endtask

  task automatic test_shift_logic();
    logic [25:0] exp;
    bus.in = mk(8'h81, 0, 0, 0, 6, 1, 0, 0, 1, 0);
    step();
    exp = pack(8'h03, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.out !== exp) begin
      errors++;
      $display("FAIL shl out=%h want=%h", bus.out, exp);
    end
    bus.in = mk(8'h81, 0, 0, 0, 7, 0, 0, 0, 1, 0);
    step();
    exp = pack(8'h40, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.out !== exp) begin
      errors++;
      $display("FAIL shr out=%h want=%h", bus.out, exp);
    end
    bus.in = mk(8'hF0, 8'h0F, 0, 0, 3, 0, 0, 0, 1, 0);
    step();
    exp = pack(8'hFF, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.out !== exp) begin
      errors++;
      $display("FAIL or out=%h want=%h", bus.out, exp);
    end
  endtask

  task automatic test_merge_prio();
    logic [25:0] exp;
    bus.in = mk(0, 0, 8'hAA, 8'h55, 0, 0, 8'h0F, 8'h28, 1, 0);
    step();
    exp = pack(0, 0, 1, 0, 0, 8'h5A, 0, 1, 5, 1);
    checks++;
    if (bus.out !== exp) begin
      errors++;
      $display("FAIL merge_prio out=%h want=%h", bus.out, exp);
    end
    bus.in = mk(0, 0, 8'hAA, 8'h55, 0, 0, 8'h0F, 0, 1, 0);
    step();
    exp = pack(0, 0, 1, 0, 0, 8'h5A, 0, 1, 0, 0);
    checks++;
    if (bus.out !== exp) begin
      errors++;
      $display("FAIL prio_zero out=%h want=%h", bus.out, exp);
    end
  endtask

  task automatic test_hold();
    logic [59:0] v;
    logic [25:0] held;
    v = mk(8'h3C, 8'hA5, 8'h12, 8'h34, 0, 1, 8'hF0, 8'h81, 1, 0);
    bus.in = v;
    step();
    held = model(v);
    for (int i = 0; i < 3; i++) begin
      bus.in = mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, 0, $urandom);
      step();
      checks++;
      if (bus.out !== held) begin
        errors++;
        $display("FAIL hold_%0d out=%h want=%h", i, bus.out, held);
      end
    end
    v = mk(8'h11, 8'h22, 8'h33, 8'h44, 4, 0, 8'h55, 8'h06, 1, 0);
    bus.in = v;
    step();
    held = model(v);
    checks++;
    if (bus.out !== held) begin
      errors++;
      $display("FAIL hold_release out=%h want=%h", bus.out, held);
    end
    for (int i = 0; i < 4; i++) begin
      bus.in = mk(8'h11, 8'h22, 8'h33, 8'h44, 4, 0, 8'h55, 8'h06, 1, $urandom);
      step();
      checks++;
      if (bus.out !== held) begin
        errors++;
        $display("FAIL reserved_%0d out=%h want=%h", i, bus.out, held);
      end
    end
  endtask

  task automatic test_async_reset();
    bus.in = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 5, 1, 8'hFF, 8'hFF, 1, 0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out !== 26'h0) begin
      errors++;
      $display("FAIL async_clear out=%h want=%h", bus.out, 26'h0);
    end
    step();
    checks++;
    if (bus.out !== 26'h0) begin
      errors++;
      $display("FAIL reset_ignores_in out=%h want=%h", bus.out, 26'h0);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.out !== model(bus.in)) begin
      errors++;
      $display("FAIL after_release out=%h want=%h", bus.out, model(bus.in));
    end
  endtask

  task automatic test_random();
    logic [25:0] exp;
    logic [59:0] v;
    exp = bus.out === model(bus.in) ? model(bus.in) : 26'h0;
    for (int i = 0; i < 300; i++) begin
      v = mk($urandom, $urandom, $urandom, $urandom, $urandom_range(0, 7), $urandom,
             $urandom, $urandom, ($urandom_range(0, 3) != 0), $urandom);
      if (i % 16 == 0) v[15:8] = v[7:0];
      if (i % 16 == 0) v[52] = 1'b1;
      bus.in = v;
      step();
      if (v[52]) exp = model(v);
      if (v[52] || i > 0) begin
        checks++;
        if (bus.out !== exp) begin
          errors++;
          $display("FAIL random_%0d in=%h out=%h want=%h", i, v, bus.out, exp);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.in = '0;
    test_reset();
    test_add_sub();
    test_shift_logic();
    test_merge_prio();
    test_hold();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
